// File: rtl/line_scheduler.sv
// line_scheduler: round-robin intake from two stroke generators into a small
// segment FIFO, then launches one segment at a time on the shared bresenham engine.
// Coordinates are held in registers that only change when a segment is popped.
module line_scheduler #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [31:0]   req0_seg,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [31:0]   req1_seg,
    output logic [7:0]    x0,
    output logic [7:0]    y0,
    output logic [7:0]    x1,
    output logic [7:0]    y1,
    output logic          start,
    input  logic          done,
    output logic          busy,
    output logic [CW-1:0] drawn_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StArm, StWait} state_e;

    state_e          state_q, state_d;
    logic [31:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            last_q;
    logic [31:0]     coord_q;
    logic [CW-1:0]   drawn_q;

    logic            full, empty;
    logic            grant0, grant1;
    logic            push0, push1, push, pop, count_inc;
    logic [31:0]     push_data;

    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign empty = (count_q == '0);

    // Round-robin grant: on a tie the requester not granted most recently wins.
    // Ready uses the registered fullness, so a pop while full frees space next cycle.
    always_comb begin
        grant0     = req0_valid && (!req1_valid || last_q);
        grant1     = req1_valid && (!req0_valid || !last_q);
        req0_ready = grant0 && !full && !reset;
        req1_ready = grant1 && !full && !reset;
        push0      = req0_valid && req0_ready;
        push1      = req1_valid && req1_ready;
        push       = push0 || push1;
        push_data  = push0 ? req0_seg : req1_seg;
    end

    // Launch sequencer; ARM exists so a done level left over from the last line is ignored.
    always_comb begin
        state_d   = state_q;
        pop       = 1'b0;
        count_inc = 1'b0;
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: state_d = StArm;
            StArm:   state_d = StWait;
            StWait: begin
                if (done) begin
                    count_inc = 1'b1;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state, FIFO pointers/occupancy, arbitration history, coordinates and line count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= 1'b1;
            coord_q  <= '0;
            drawn_q  <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                last_q   <= push1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                coord_q  <= mem_q[rd_ptr_q];
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (count_inc) begin
                drawn_q <= drawn_q + 1'b1;
            end
        end
    end

    // Segment storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign x0          = coord_q[31:24];
    assign y0          = coord_q[23:16];
    assign x1          = coord_q[15:8];
    assign y1          = coord_q[7:0];
    assign start       = (state_q == StStart) && !reset;
    assign busy        = ((state_q != StIdle) || !empty) && !reset;
    assign drawn_count = drawn_q;

endmodule
